cr_lsu_unalign: RTL



---
 rtl/cr_lsu_pkg.sv | 35 +++
 rtl/cr_lsu_unalign_if.sv | 23 ++
 rtl/cr_lsu_unalign_asm.sv | 43 ++++
 rtl/cr_lsu_unalign.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cr_lsu_pkg.sv
// Shared LSU definitions: unaligned-splitter state encoding, access size codes
// and beat-count helpers. Used by cr_lsu_unalign (macro CR_LSU_UNALIGN_SPLIT_EN).
package cr_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } unalign_state_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  // Number of byte beats needed to split an access of the given size.
  function automatic logic [2:0] beat_cnt(input logic [1:0] size);
    case (size)
      SizeHalf: return 3'd2;
      SizeWord: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

  // Index of the final beat.
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    logic [2:0] n;
    n = beat_cnt(size) - 3'd1;
    return n[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SizeHalf) && addr_lo[0]) || ((size == SizeWord) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/cr_lsu_unalign_if.sv
// Beat bus between the unaligned splitter (master) and the BMU (slave).
interface cr_lsu_unalign_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              unalign_bmu_req;
  logic [ADDR_W-1:0] unalign_bmu_addr;
  logic [31:0]       unalign_bmu_wdata;
  logic              unalign_bmu_write;
  logic              bmu_lsu_grnt;
  logic              bmu_lsu_trans_cmplt;
  logic              bmu_lsu_acc_err;
  logic [31:0]       bmu_lsu_rdata;

  modport master (
    output unalign_bmu_req, unalign_bmu_addr, unalign_bmu_wdata, unalign_bmu_write,
    input  bmu_lsu_grnt, bmu_lsu_trans_cmplt, bmu_lsu_acc_err, bmu_lsu_rdata
  );

  modport slave (
    input  unalign_bmu_req, unalign_bmu_addr, unalign_bmu_wdata, unalign_bmu_write,
    output bmu_lsu_grnt, bmu_lsu_trans_cmplt, bmu_lsu_acc_err, bmu_lsu_rdata
  );
endinterface

// File: rtl/cr_lsu_unalign_asm.sv
// Load reassembly for split accesses: picks the addressed byte lane of each
// beat into a 4x8 assembly register and sign/zero-extends half results.
// Only present when CR_LSU_UNALIGN_SPLIT_EN is defined.
`ifdef CR_LSU_UNALIGN_SPLIT_EN
module cr_lsu_unalign_asm (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_cap,
  input  logic [1:0]  i_beat,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic        i_half,
  input  logic        i_sign,
  output logic [31:0] o_rdata
);

  logic [3:0][7:0] r_asm;
  logic [7:0]      w_lane_byte;

  assign w_lane_byte = i_rdata[{i_lane, 3'b000} +: 8];

  // Clear at sequence start, capture one byte per completed load beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm <= '0;
    end else if (i_clr) begin
      r_asm <= '0;
    end else if (i_cap) begin
      r_asm[i_beat] <= w_lane_byte;
    end
  end

  // Half results are extended from bit 15; word results pass as assembled.
  always_comb begin
    o_rdata = r_asm;
    if (i_half) begin
      o_rdata = {{16{i_sign & r_asm[1][7]}}, r_asm[1], r_asm[0]};
    end
  end

endmodule
`endif

// File: rtl/cr_lsu_unalign.sv
// Misaligned load/store splitter. Breaks a misaligned half/word access into
// byte beats on the d-bus and reassembles load data.
// Macro CR_LSU_UNALIGN_SPLIT_EN: defined -> splitter built; undefined ->
// splitter removed and misaligned accesses flag unalign_dp_misalign_expt.
module cr_lsu_unalign #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               sm_clk,
  input  logic               cpurst_b,
  input  logic               iu_yy_xx_flush,
  input  logic               iu_lsu_ex_data_sel,
  input  logic               iu_lsu_ex_store,
  input  logic               iu_lsu_ex_sign,
  input  logic [1:0]         iu_lsu_ex_size,
  input  logic [ADDR_W-1:0]  iu_lsu_ex_addr,
  input  logic [31:0]        iu_lsu_ex_wdata,
  cr_lsu_unalign_if.master   bmu,
  output logic               unalign_xx_split_on,
  output logic               unalign_ctrl_stall,
  output logic               unalign_ctrl_not_last_beat,
  output logic [31:0]        unalign_iu_rdata,
  output logic               unalign_iu_cmplt,
  output logic               unalign_iu_acc_err,
  output logic               unalign_dp_misalign_expt
);

  import cr_lsu_pkg::*;

  logic w_start;

  assign w_start = iu_lsu_ex_data_sel && is_misaligned(iu_lsu_ex_size, iu_lsu_ex_addr[1:0]);

`ifdef CR_LSU_UNALIGN_SPLIT_EN

  unalign_state_e    r_state;
  logic [1:0]        r_beat;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic              r_store;
  logic              r_sign;
  logic [31:0]       r_wdata;

  logic              w_idle;
  logic              w_req;
  logic              w_last;
  logic              w_fin;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [7:0]        w_beat_byte;

  assign w_idle      = (r_state == StIdle);
  assign w_req       = (r_state == StReq);
  assign w_last      = (r_beat == last_beat(r_size));
  assign w_beat_addr = r_addr + {{(ADDR_W-2){1'b0}}, r_beat};
  assign w_beat_byte = r_wdata[{r_beat, 3'b000} +: 8];
  // Beat completion; a flush in the same cycle swallows it.
  assign w_fin       = (r_state == StWait) && bmu.bmu_lsu_trans_cmplt && !iu_yy_xx_flush;

  // Sequence FSM: latch the access on entry, step beats on completion.
  always_ff @(posedge sm_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= StIdle;
      r_beat  <= 2'd0;
      r_size  <= SizeByte;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_sign  <= 1'b0;
      r_wdata <= '0;
    end else if (iu_yy_xx_flush) begin
      r_state <= StIdle;
      r_beat  <= 2'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= StReq;
            r_beat  <= 2'd0;
            r_size  <= iu_lsu_ex_size;
            r_addr  <= iu_lsu_ex_addr;
            r_store <= iu_lsu_ex_store;
            r_sign  <= iu_lsu_ex_sign;
            r_wdata <= iu_lsu_ex_wdata;
          end
        end
        StReq: begin
          if (bmu.bmu_lsu_grnt) r_state <= StWait;
        end
        StWait: begin
          if (bmu.bmu_lsu_trans_cmplt) begin
            if (bmu.bmu_lsu_acc_err || w_last) begin
              r_state <= StIdle;
              r_beat  <= 2'd0;
            end else begin
              r_state <= StReq;
              r_beat  <= r_beat + 2'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bmu.unalign_bmu_req   = w_req;
  assign bmu.unalign_bmu_addr  = w_req ? w_beat_addr : '0;
  assign bmu.unalign_bmu_wdata = w_req ? {4{w_beat_byte}} : 32'd0;
  assign bmu.unalign_bmu_write = w_req && r_store;

  assign unalign_xx_split_on        = !w_idle;
  assign unalign_ctrl_stall         = !w_idle || w_start;
  assign unalign_ctrl_not_last_beat = !w_idle && !w_last;
  assign unalign_iu_cmplt           = w_fin && !bmu.bmu_lsu_acc_err && w_last;
  assign unalign_iu_acc_err         = w_fin && bmu.bmu_lsu_acc_err;
  assign unalign_dp_misalign_expt   = 1'b0;

  cr_lsu_unalign_asm u_asm (
    .i_clk   (sm_clk),
    .i_rst_n (cpurst_b),
    .i_clr   (w_idle && w_start && !iu_yy_xx_flush),
    .i_cap   (w_fin && !bmu.bmu_lsu_acc_err && !r_store),
    .i_beat  (r_beat),
    .i_lane  (w_beat_addr[1:0]),
    .i_rdata (bmu.bmu_lsu_rdata),
    .i_half  (r_size == SizeHalf),
    .i_sign  (r_sign),
    .o_rdata (unalign_iu_rdata)
  );

`else

  logic w_unused;

  assign w_unused = ^{sm_clk, cpurst_b, iu_yy_xx_flush, iu_lsu_ex_store, iu_lsu_ex_sign,
                      iu_lsu_ex_addr, iu_lsu_ex_wdata, bmu.bmu_lsu_grnt,
                      bmu.bmu_lsu_trans_cmplt, bmu.bmu_lsu_acc_err, bmu.bmu_lsu_rdata};

  assign bmu.unalign_bmu_req        = 1'b0;
  assign bmu.unalign_bmu_addr       = '0;
  assign bmu.unalign_bmu_wdata      = 32'd0;
  assign bmu.unalign_bmu_write      = 1'b0;
  assign unalign_xx_split_on        = 1'b0;
  assign unalign_ctrl_stall         = 1'b0;
  assign unalign_ctrl_not_last_beat = 1'b0;
  assign unalign_iu_rdata           = 32'd0;
  assign unalign_iu_cmplt           = 1'b0;
  assign unalign_iu_acc_err         = 1'b0;
  assign unalign_dp_misalign_expt   = w_start;

`endif

endmodule
